// File: rtl/conv_pool_mc.sv
// conv_pool_mc: multi-kernel 3x3 convolution + 2x2 pooling engine.
// Reads 4x4 pixel tiles from input memory, convolves each tile with NUM_K
// signed 3x3 kernels (four overlapping windows each), pools the four window
// results (max or average) and writes one byte per kernel per tile.
// Ports:
//   clk, rst_n      clock (rising edge), async active-low reset
//   start           one-cycle run request, only honoured in IDLE
//   num_blocks      tile count, latched with start
//   pool_mode       0 = max, 1 = average, latched with start
//   shift           extra right shift (total shift+3), latched with start
//   conv_kernels    NUM_K packed 3x3 signed kernels, latched with start
//   image_4x4       tile data, valid RD_LAT cycles after input_re
//   input_re/addr   input memory read strobe and tile address
//   out_we/addr, y  output write strobe, address and pooled bytes
//   busy, done      run in progress / one-cycle end-of-run pulse
//
// state  | meaning
// IDLE   | waiting for start
// ISSUE  | one read strobe per cycle, addresses 0..num_blocks-1
// DRAIN  | all strobes issued, waiting for the last write
// DONE   | one-cycle done pulse
module conv_pool_mc #(
    parameter int NUM_K  = 3,
    parameter int ADDR_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     num_blocks,
    input  logic                  pool_mode,
    input  logic [1:0]            shift,
    input  logic [NUM_K*72-1:0]   conv_kernels,
    input  logic [127:0]          image_4x4,
    output logic                  input_re,
    output logic [ADDR_W-1:0]     input_addr,
    output logic                  out_we,
    output logic [ADDR_W-1:0]     out_addr,
    output logic [NUM_K*8-1:0]    y,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t                state;
    logic [ADDR_W-1:0]     remain;
    logic                  mode_q;
    logic [1:0]            shift_q;
    logic [NUM_K*72-1:0]   kern_q;

    logic [RD_LAT-1:0]     rd_v;
    logic [ADDR_W-1:0]     rd_a [RD_LAT];
    logic                  conv_v;
    logic [ADDR_W-1:0]     conv_a;
    logic [NUM_K*32-1:0]   win_q;
    logic [NUM_K*32-1:0]   win_d;
    logic [NUM_K*8-1:0]    y_d;

    // One 3x3 window at (ro,co): signed MAC, arithmetic shift, clamp to a byte.
    // 21 bits covers 9 * 255 * 128 with margin, so the sum never overflows.
    function automatic logic [7:0] win_val(input logic [71:0] kern,
                                           input logic [127:0] img,
                                           input int ro, input int co,
                                           input logic [1:0] sh);
        logic signed [20:0] acc;
        logic signed [20:0] px;
        logic signed [20:0] cf;
        logic signed [20:0] res;
        logic [2:0]         amt;
        acc = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                px  = {13'd0, img[((ro + i) * 4 + co + j) * 8 +: 8]};
                cf  = {{13{kern[(i * 3 + j) * 8 + 7]}}, kern[(i * 3 + j) * 8 +: 8]};
                acc = acc + px * cf;
            end
        end
        amt = {1'b0, sh} + 3'd3;
        res = acc >>> amt;
        if (res < 0)
            return 8'd0;
        else if (res > 21'sd255)
            return 8'hFF;
        else
            return res[7:0];
    endfunction

    function automatic logic [7:0] pool4(input logic [31:0] w, input logic avg);
        logic [7:0] mx;
        logic [9:0] s;
        mx = w[7:0];
        s  = '0;
        for (int i = 0; i < 4; i++) begin
            if (w[i * 8 +: 8] > mx)
                mx = w[i * 8 +: 8];
            s = s + {2'b00, w[i * 8 +: 8]};
        end
        return avg ? 8'(s >> 2) : mx;
    endfunction

    always_comb begin
        win_d = '0;
        for (int k = 0; k < NUM_K; k++)
            for (int w = 0; w < 4; w++)
                win_d[(k * 4 + w) * 8 +: 8] = win_val(kern_q[k * 72 +: 72], image_4x4,
                                                      w / 2, w % 2, shift_q);
    end

    always_comb begin
        y_d = '0;
        for (int k = 0; k < NUM_K; k++)
            y_d[k * 8 +: 8] = pool4(win_q[k * 32 +: 32], mode_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            remain     <= '0;
            mode_q     <= 1'b0;
            shift_q    <= '0;
            kern_q     <= '0;
            input_re   <= 1'b0;
            input_addr <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_q  <= pool_mode;
                        shift_q <= shift;
                        kern_q  <= conv_kernels;
                        busy    <= 1'b1;
                        if (num_blocks == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= S_ISSUE;
                            input_re   <= 1'b1;
                            input_addr <= '0;
                            remain     <= num_blocks - ADDR_W'(1);
                        end
                    end
                end
                S_ISSUE: begin
                    // remain counts strobes still owed after the current one
                    if (remain == '0) begin
                        input_re <= 1'b0;
                        state    <= S_DRAIN;
                    end else begin
                        remain     <= remain - ADDR_W'(1);
                        input_addr <= input_addr + ADDR_W'(1);
                    end
                end
                S_DRAIN: begin
                    // last write is the one presented with nothing left behind it
                    if (out_we && !(|rd_v) && !conv_v) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_v     <= '0;
            for (int i = 0; i < RD_LAT; i++)
                rd_a[i] <= '0;
            conv_v   <= 1'b0;
            conv_a   <= '0;
            win_q    <= '0;
            out_we   <= 1'b0;
            out_addr <= '0;
            y        <= '0;
        end else begin
            rd_v[0] <= input_re;
            rd_a[0] <= input_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                rd_v[i] <= rd_v[i - 1];
                rd_a[i] <= rd_a[i - 1];
            end
            conv_v <= rd_v[RD_LAT - 1];
            if (rd_v[RD_LAT - 1]) begin
                conv_a <= rd_a[RD_LAT - 1];
                win_q  <= win_d;
            end
            out_we <= conv_v;
            if (conv_v) begin
                out_addr <= conv_a;
                y        <= y_d;
            end
        end
    end

endmodule
